// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte handshake and transmit-buffer load port of the UART TX arbiter.
// slave = arbiter side, master = requesters plus transmit buffer.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic [7:0]           tx_data;
  logic                 tx_data_clk;
  logic                 tx_busy;
  logic                 tx_idle;
  logic                 abort_err;

  modport slave (
    input  req_valid, req_data, req_last, tx_busy, tx_idle,
    output req_ready, grant, tx_data, tx_data_clk, abort_err
  );

  modport master (
    output req_valid, req_data, req_last, tx_busy, tx_idle,
    input  req_ready, grant, tx_data, tx_data_clk, abort_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting whole byte messages from NUM_REQ requesters to one UART transmit buffer.
// Latency: grant 1 cycle after request, load strobe 1 cycle after accept; backpressure: tx_busy drops req_ready.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int GAP_TIMEOUT = 65535,
  parameter int DRAIN       = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int          LG_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] GAP_LIM = 16'(GAP_TIMEOUT);

  typedef enum logic [1:0] {IDLE, XFER, STROBE, DRAIN_WAIT} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_q, grant_nxt;
  logic [LG_W-1:0]    cur_idx, cur_idx_nxt;
  logic [LG_W-1:0]    last_grant, last_grant_nxt;
  logic [LG_W-1:0]    pick_idx;
  logic               pick_vld;
  logic [7:0]         tx_data_q, tx_data_nxt;
  logic               strobe_q, strobe_nxt;
  logic               abort_q, abort_nxt;
  logic               last_q, last_nxt;
  logic [15:0]        gap_cnt, gap_nxt, gap_inc;
  logic               cur_vld;
  logic               accept;
  logic [7:0]         cur_dat;

  assign cur_vld       = bus.req_valid[cur_idx];
  assign cur_dat       = bus.req_data[{cur_idx, 3'b000} +: 8];
  assign bus.req_ready = (state == XFER && !bus.tx_busy) ? grant_q : '0;
  assign accept        = |(bus.req_valid & bus.req_ready);
  assign gap_inc       = (gap_cnt == 16'hFFFF) ? gap_cnt : gap_cnt + 16'd1;

  assign bus.grant       = grant_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_data_clk = strobe_q;
  assign bus.abort_err   = abort_q;

  // Search starts one past the previous owner so the last winner has lowest priority.
  always_comb begin : p_pick
    int              cand;
    logic [LG_W-1:0] cand_idx;
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand     = (int'(last_grant) + i) % NUM_REQ;
      cand_idx = LG_W'(cand);
      if (!pick_vld && bus.req_valid[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  always_comb begin : p_fsm
    state_nxt      = state;
    grant_nxt      = grant_q;
    cur_idx_nxt    = cur_idx;
    last_grant_nxt = last_grant;
    tx_data_nxt    = tx_data_q;
    strobe_nxt     = 1'b0;
    abort_nxt      = 1'b0;
    last_nxt       = last_q;
    gap_nxt        = gap_cnt;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          grant_nxt   = NUM_REQ'(1) << pick_idx;
          cur_idx_nxt = pick_idx;
          gap_nxt     = '0;
          state_nxt   = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          tx_data_nxt = cur_dat;
          strobe_nxt  = 1'b1;
          last_nxt    = bus.req_last[cur_idx];
          gap_nxt     = '0;
          state_nxt   = STROBE;
        end else if (!cur_vld) begin
          // Only an absent byte counts as a gap; a tx_busy stall does not.
          gap_nxt = gap_inc;
          if (gap_inc == GAP_LIM) begin
            abort_nxt      = 1'b1;
            grant_nxt      = '0;
            last_grant_nxt = cur_idx;
            gap_nxt        = '0;
            state_nxt      = IDLE;
          end
        end
      end
      STROBE: begin
        if (!last_q) begin
          gap_nxt   = '0;
          state_nxt = XFER;
        end else if (DRAIN != 0) begin
          state_nxt = DRAIN_WAIT;
        end else begin
          grant_nxt      = '0;
          last_grant_nxt = cur_idx;
          state_nxt      = IDLE;
        end
      end
      DRAIN_WAIT: begin
        if (bus.tx_idle) begin
          grant_nxt      = '0;
          last_grant_nxt = cur_idx;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_q    <= '0;
      cur_idx    <= '0;
      last_grant <= LG_W'(NUM_REQ - 1);
      tx_data_q  <= '0;
      strobe_q   <= 1'b0;
      abort_q    <= 1'b0;
      last_q     <= 1'b0;
      gap_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      grant_q    <= grant_nxt;
      cur_idx    <= cur_idx_nxt;
      last_grant <= last_grant_nxt;
      tx_data_q  <= tx_data_nxt;
      strobe_q   <= strobe_nxt;
      abort_q    <= abort_nxt;
      last_q     <= last_nxt;
      gap_cnt    <= gap_nxt;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic scored against a message-level model.
// dut_a drains on tx_idle, dut_b releases straight after the last strobe; both abort after 8 idle cycles.
module tb_uart_tx_arbiter;
  typedef logic [8:0] ent_t;   // {last, data}

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(3)) ifa ();
  uart_tx_arbiter_if #(.NUM_REQ(3)) ifb ();

  uart_tx_arbiter #(.NUM_REQ(3), .GAP_TIMEOUT(8), .DRAIN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  uart_tx_arbiter #(.NUM_REQ(3), .GAP_TIMEOUT(8), .DRAIN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  int n_err = 0;
  int n_chk = 0;
  int cyc_n = 0;

  ent_t mq  [3][$];
  ent_t mqb [3][$];
  ent_t mdl [3][$];
  logic busy_force, idle_force, rnd_busy, rnd_idle, rnd_bub;
  int   bub_run [3];

  int         st_cyc[$];
  logic [7:0] st_dat[$];
  int         ab_cyc[$];
  logic [2:0] gnt_log[$];
  logic [2:0] prev_gnt_a;
  int         last_st_a;

  int         stb_cyc[$];
  logic [7:0] stb_dat[$];
  logic [2:0] gntb_log[$];
  logic [2:0] prev_gnt_b;
  int         last_st_b;

  logic [2:0] exp_own[$];
  logic [7:0] exp_b[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    st_cyc.delete(); st_dat.delete(); ab_cyc.delete(); gnt_log.delete();
    stb_cyc.delete(); stb_dat.delete(); gntb_log.delete();
    prev_gnt_a = '0; prev_gnt_b = '0;
    last_st_a = -1000; last_st_b = -1000;
  endtask

  // One clock: drive inputs at +1, observe and score at +2.
  task automatic cyc();
    ent_t       e;
    logic       bub;
    logic [2:0] acc_a, acc_b;
    @(posedge clk);
    #1;
    cyc_n++;
    for (int k = 0; k < 3; k++) begin
      bub = rnd_bub && ifa.grant[k] && (bub_run[k] < 3) && ($urandom_range(3) == 0);
      if (bub) bub_run[k]++;
      if (mq[k].size() > 0 && !bub) begin
        e = mq[k][0];
        ifa.req_valid[k] = 1'b1; ifa.req_data[8*k +: 8] = e[7:0]; ifa.req_last[k] = e[8];
      end else begin
        ifa.req_valid[k] = 1'b0; ifa.req_data[8*k +: 8] = 8'h00; ifa.req_last[k] = 1'b0;
      end
      if (mqb[k].size() > 0) begin
        e = mqb[k][0];
        ifb.req_valid[k] = 1'b1; ifb.req_data[8*k +: 8] = e[7:0]; ifb.req_last[k] = e[8];
      end else begin
        ifb.req_valid[k] = 1'b0; ifb.req_data[8*k +: 8] = 8'h00; ifb.req_last[k] = 1'b0;
      end
    end
    ifa.tx_busy = busy_force | (rnd_busy && ($urandom_range(3) == 0));
    ifa.tx_idle = idle_force | (rnd_idle && ($urandom_range(1) == 1));
    #1;
    chk("a_ready_outside_grant", {29'd0, ifa.req_ready & ~ifa.grant}, 0);
    chk("a_grant_onehot0", {31'd0, $onehot0(ifa.grant)}, 1);
    chk("b_ready_outside_grant", {29'd0, ifb.req_ready & ~ifb.grant}, 0);
    if (ifa.tx_busy) chk("a_ready_while_busy", {29'd0, ifa.req_ready}, 0);
    if (ifa.tx_data_clk) begin
      chk("a_strobe_spacing", {31'd0, (cyc_n - last_st_a) >= 2}, 1);
      last_st_a = cyc_n;
      st_cyc.push_back(cyc_n);
      st_dat.push_back(ifa.tx_data);
    end
    if (ifb.tx_data_clk) begin
      chk("b_strobe_spacing", {31'd0, (cyc_n - last_st_b) >= 2}, 1);
      last_st_b = cyc_n;
      stb_cyc.push_back(cyc_n);
      stb_dat.push_back(ifb.tx_data);
    end
    if (ifa.abort_err) ab_cyc.push_back(cyc_n);
    if (ifa.grant != 3'b000 && prev_gnt_a == 3'b000) gnt_log.push_back(ifa.grant);
    if (ifb.grant != 3'b000 && prev_gnt_b == 3'b000) gntb_log.push_back(ifb.grant);
    prev_gnt_a = ifa.grant;
    prev_gnt_b = ifb.grant;
    acc_a = ifa.req_valid & ifa.req_ready;
    acc_b = ifb.req_valid & ifb.req_ready;
    for (int k = 0; k < 3; k++) begin
      if (acc_a[k]) begin void'(mq[k].pop_front()); bub_run[k] = 0; end
      if (acc_b[k]) void'(mqb[k].pop_front());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mq[k].delete(); mqb[k].delete(); mdl[k].delete(); bub_run[k] = 0;
    end
    busy_force = 1'b0; idle_force = 1'b0;
    rnd_busy = 1'b0; rnd_idle = 1'b0; rnd_bub = 1'b0;
    repeat (2) cyc();
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic run_strobes(input string tag, input int n, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (st_cyc.size() >= n) break;
      cyc();
    end
    chk(tag, st_cyc.size(), n);
  endtask

  task automatic push_a(input int k, input logic [7:0] d, input logic last);
    mq[k].push_back({last, d});
  endtask

  // Message-level reference: owners rotate from the previous winner among requesters with messages left.
  task automatic build_model();
    int   last, cand;
    ent_t e;
    logic done;
    exp_own.delete(); exp_b.delete();
    last = 2;
    for (int guard = 0; guard < 64; guard++) begin
      cand = -1;
      for (int i = 1; i <= 3; i++)
        if (cand < 0 && mdl[(last + i) % 3].size() > 0) cand = (last + i) % 3;
      if (cand < 0) break;
      exp_own.push_back(3'(1 << cand));
      done = 1'b0;
      while (!done) begin
        e = mdl[cand].pop_front();
        exp_b.push_back(e[7:0]);
        done = e[8];
      end
      last = cand;
    end
  endtask

  initial begin
    int s, nb, nm, len;
    ent_t e;
    rst_n = 1'b0;
    ifa.req_valid = '0; ifa.req_data = '0; ifa.req_last = '0; ifa.tx_busy = 1'b0; ifa.tx_idle = 1'b0;
    ifb.req_valid = '0; ifb.req_data = '0; ifb.req_last = '0; ifb.tx_busy = 1'b0; ifb.tx_idle = 1'b0;
    busy_force = 1'b0; idle_force = 1'b0; rnd_busy = 1'b0; rnd_idle = 1'b0; rnd_bub = 1'b0;
    for (int k = 0; k < 3; k++) bub_run[k] = 0;
    clear_logs();

    // Reset state with a request pending.
    push_a(0, 8'h55, 1'b1);
    repeat (3) cyc();
    chk("rst_grant", {29'd0, ifa.grant}, 0);
    chk("rst_ready", {29'd0, ifa.req_ready}, 0);
    chk("rst_tx_data", {24'd0, ifa.tx_data}, 0);
    chk("rst_strobe", {31'd0, ifa.tx_data_clk}, 0);
    chk("rst_abort", {31'd0, ifa.abort_err}, 0);

    // "Hi!" from requester 1, then drain until tx_idle.
    do_reset();
    push_a(1, 8'h48, 1'b0); push_a(1, 8'h69, 1'b0); push_a(1, 8'h21, 1'b1);
    run_strobes("hi_strobe_count", 3, 40);
    if (st_cyc.size() == 3) begin
      chk("hi_byte0", {24'd0, st_dat[0]}, 32'h48);
      chk("hi_byte1", {24'd0, st_dat[1]}, 32'h69);
      chk("hi_byte2", {24'd0, st_dat[2]}, 32'h21);
      chk("hi_gap01", st_cyc[1] - st_cyc[0], 2);
      chk("hi_gap12", st_cyc[2] - st_cyc[1], 2);
    end
    chk("hi_owner", {29'd0, gnt_log[0]}, 32'h2);
    repeat (5) begin
      cyc();
      chk("hi_drain_hold", {29'd0, ifa.grant}, 32'h2);
    end
    idle_force = 1'b1;
    cyc();
    chk("hi_grant_at_idle", {29'd0, ifa.grant}, 32'h2);
    cyc();
    chk("hi_grant_released", {29'd0, ifa.grant}, 0);
    chk("hi_no_abort", ab_cyc.size(), 0);

    // Round robin with all three holding 1-byte messages.
    do_reset();
    idle_force = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 3; k++) push_a(k, 8'(8'hA0 + 3 * r + k), 1'b1);
    run_strobes("rr_strobe_count", 6, 80);
    for (int i = 0; i < 6; i++) begin
      if (i < gnt_log.size()) chk("rr_grant_order", {29'd0, gnt_log[i]}, 32'(1 << (i % 3)));
      if (i < st_dat.size()) chk("rr_data", {24'd0, st_dat[i]}, 32'(8'hA0 + i));
    end

    // tx_busy stall for 10 cycles mid-message.
    do_reset();
    idle_force = 1'b1;
    for (int i = 0; i < 4; i++) push_a(0, 8'(8'hC0 + i), i == 3);
    run_strobes("busy_first_strobe", 1, 20);
    busy_force = 1'b1;
    repeat (10) begin
      cyc();
      chk("busy_ready_low", {29'd0, ifa.req_ready}, 0);
    end
    chk("busy_no_strobe", st_cyc.size(), 1);
    chk("busy_no_abort", ab_cyc.size(), 0);
    busy_force = 1'b0;
    run_strobes("busy_resume_count", 4, 40);
    for (int i = 0; i < 4; i++)
      if (i < st_dat.size()) chk("busy_data", {24'd0, st_dat[i]}, 32'(8'hC0 + i));
    chk("busy_no_abort_end", ab_cyc.size(), 0);

    // Gap timeout: requester 1 stops after 2 bytes, requester 2 waits.
    do_reset();
    idle_force = 1'b1;
    push_a(1, 8'hD0, 1'b0); push_a(1, 8'hD1, 1'b0);
    push_a(2, 8'hE0, 1'b1);
    run_strobes("gap_two_strobes", 2, 30);
    s = st_cyc[st_cyc.size() - 1];
    repeat (30) cyc();
    chk("gap_abort_pulses", ab_cyc.size(), 1);
    if (ab_cyc.size() > 0) chk("gap_abort_delay", ab_cyc[0] - (s + 1), 8);
    chk("gap_grant_count", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      chk("gap_first_owner", {29'd0, gnt_log[0]}, 32'h2);
      chk("gap_next_owner", {29'd0, gnt_log[1]}, 32'h4);
    end
    chk("gap_strobe_count", st_cyc.size(), 3);
    if (st_dat.size() == 3) chk("gap_next_data", {24'd0, st_dat[2]}, 32'hE0);

    // Reset pulse between strobes of a 4-byte message.
    do_reset();
    idle_force = 1'b1;
    for (int i = 0; i < 4; i++) push_a(0, 8'(8'hF0 + i), i == 3);
    run_strobes("mrst_two_strobes", 2, 30);
    cyc();
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_grant", {29'd0, ifa.grant}, 0);
    chk("mrst_ready", {29'd0, ifa.req_ready}, 0);
    chk("mrst_tx_data", {24'd0, ifa.tx_data}, 0);
    chk("mrst_strobe", {31'd0, ifa.tx_data_clk}, 0);
    chk("mrst_abort", {31'd0, ifa.abort_err}, 0);
    mq[0].delete();
    cyc();
    @(negedge clk);
    rst_n = 1'b1;
    nb = st_cyc.size();
    push_a(1, 8'h5A, 1'b1);
    repeat (15) cyc();
    chk("mrst_strobes_after", st_cyc.size(), nb + 1);
    if (st_cyc.size() == nb + 1) chk("mrst_new_data", {24'd0, st_dat[nb]}, 32'h5A);
    chk("mrst_new_owner", {29'd0, gnt_log[gnt_log.size() - 1]}, 32'h2);
    chk("mrst_no_abort", ab_cyc.size(), 0);

    // No-drain variant, back-to-back messages from requesters 0 and 1, tx_idle never high.
    do_reset();
    mqb[0].push_back({1'b0, 8'h10}); mqb[0].push_back({1'b1, 8'h11});
    mqb[1].push_back({1'b0, 8'h20}); mqb[1].push_back({1'b1, 8'h21});
    for (int i = 0; i < 40; i++) begin
      if (stb_cyc.size() >= 4) break;
      cyc();
    end
    chk("nodrain_strobe_count", stb_cyc.size(), 4);
    if (stb_cyc.size() == 4) begin
      chk("nodrain_data0", {24'd0, stb_dat[0]}, 32'h10);
      chk("nodrain_data2", {24'd0, stb_dat[2]}, 32'h20);
      chk("nodrain_handover", {31'd0, (stb_cyc[2] - stb_cyc[1]) >= 3}, 1);
    end
    chk("nodrain_owners", gntb_log.size(), 2);

    // Randomized traffic scored against the message-level model.
    do_reset();
    rnd_busy = 1'b1; rnd_idle = 1'b1; rnd_bub = 1'b1;
    for (int k = 0; k < 3; k++) begin
      nm = $urandom_range(3, 1);
      for (int m = 0; m < nm; m++) begin
        len = $urandom_range(4, 1);
        for (int b = 0; b < len; b++) begin
          e = {b == len - 1, 8'($urandom)};
          mq[k].push_back(e);
          mdl[k].push_back(e);
        end
      end
    end
    build_model();
    run_strobes("rnd_strobe_count", exp_b.size(), 4000);
    for (int i = 0; i < exp_b.size(); i++)
      if (i < st_dat.size()) chk("rnd_data", {24'd0, st_dat[i]}, {24'd0, exp_b[i]});
    repeat (20) cyc();
    chk("rnd_owner_count", gnt_log.size(), exp_own.size());
    for (int i = 0; i < exp_own.size(); i++)
      if (i < gnt_log.size()) chk("rnd_owner", {29'd0, gnt_log[i]}, {29'd0, exp_own[i]});
    chk("rnd_no_abort", ab_cyc.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
